// File: rtl/rf_pkg.sv
// Shared types and defaults for the multi-port register file.
// Imported by the write-merge sub-module and the register_file_mp top.
package rf_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } rf_state_e;

  localparam int RF_DATA_W = 64;
  localparam int RF_DEPTH  = 32;

  // Address width that stays at least 1 bit even for degenerate depths.
  function automatic int rf_aw(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/rf_wr_merge.sv
// Priority merge of all write ports into one winning enable/data per register.
// The result drives both the storage update and the same-cycle read bypass.
module rf_wr_merge
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int DEPTH    = RF_DEPTH,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 0,
  parameter int AW       = rf_aw(DEPTH)
) (
  input  logic [NUM_WR-1:0]        write_en,
  input  logic [NUM_WR*AW-1:0]     waddr,
  input  logic [NUM_WR*DATA_W-1:0] wdata,
  output logic [DEPTH-1:0]         win_en,
  output logic [DEPTH*DATA_W-1:0]  win_data,
  output logic                     conflict
);

  always_comb begin
    win_en   = '0;
    win_data = '0;
    for (int a = 0; a < DEPTH; a++) begin
      for (int j = 0; j < NUM_WR; j++) begin
        // NOTE: blocking assignments in a comb loop let a later (higher) port
        // overwrite an earlier one, which is exactly the priority we want.
        if (write_en[j] && (waddr[j*AW +: AW] == AW'(a))) begin
          win_en[a]                    = 1'b1;
          win_data[a*DATA_W +: DATA_W] = wdata[j*DATA_W +: DATA_W];
        end
      end
    end
    if (ZERO_REG != 0) begin
      win_en[0]            = 1'b0;
      win_data[DATA_W-1:0] = '0;
    end
  end

  // Conflicts are judged on raw enables, so dropped zero-register writes count.
  always_comb begin
    conflict = 1'b0;
    for (int j = 0; j < NUM_WR; j++) begin
      for (int k = j + 1; k < NUM_WR; k++) begin
        if (write_en[j] && write_en[k] &&
            (waddr[j*AW +: AW] == waddr[k*AW +: AW])) begin
          conflict = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/register_file_mp.sv
// Parametrised N-read / M-write register file with registered reads,
// write-first bypass, write-conflict flag and a self-clearing init sequencer.
module register_file_mp
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int DEPTH    = RF_DEPTH,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 0,
  parameter int AW       = rf_aw(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  output logic                     ready,
  input  logic [NUM_RD-1:0]        read_en,
  input  logic [NUM_RD*AW-1:0]     raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rvalid,
  input  logic [NUM_WR-1:0]        write_en,
  input  logic [NUM_WR*AW-1:0]     waddr,
  input  logic [NUM_WR*DATA_W-1:0] wdata,
  output logic                     wr_conflict
);

  rf_state_e             state, state_nxt;
  logic [AW-1:0]         init_ptr;
  logic                  init_we;
  logic [DATA_W-1:0]     mem [DEPTH];
  logic [NUM_WR-1:0]     wr_en_g;
  logic [DEPTH-1:0]      win_en;
  logic [DEPTH*DATA_W-1:0] win_data;
  logic                  conflict;
  logic [DATA_W-1:0]     rd_word [NUM_RD];

  // ---------------- init FSM ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= INIT;
    else          state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    unique case (state)
      INIT:    if (init_ptr == AW'(DEPTH - 1)) state_nxt = READY;
      READY:   state_nxt = READY;
      default: state_nxt = INIT;
    endcase
  end

  always_comb begin
    ready   = (state == READY);
    init_we = (state == INIT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     init_ptr <= '0;
    else if (init_we) init_ptr <= init_ptr + 1'b1;
  end

  // ---------------- write path ----------------
  assign wr_en_g = write_en & {NUM_WR{ready}};

  rf_wr_merge #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .NUM_WR  (NUM_WR),
    .ZERO_REG(ZERO_REG),
    .AW      (AW)
  ) u_wr_merge (
    .write_en(wr_en_g),
    .waddr   (waddr),
    .wdata   (wdata),
    .win_en  (win_en),
    .win_data(win_data),
    .conflict(conflict)
  );

  // NOTE: the storage array has no reset; the INIT sequencer clears it after
  // every reset, so it can map onto plain flops or RAM without a reset net.
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[init_ptr] <= '0;
    end else begin
      for (int a = 0; a < DEPTH; a++) begin
        if (win_en[a]) mem[a] <= win_data[a*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) wr_conflict <= 1'b0;
    else          wr_conflict <= conflict;
  end

  // ---------------- read path ----------------
  // Write-first: a same-cycle winning write overrides the stored word.
  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      rd_word[i] = mem[raddr[i*AW +: AW]];
      if (win_en[raddr[i*AW +: AW]]) begin
        rd_word[i] = win_data[int'(raddr[i*AW +: AW])*DATA_W +: DATA_W];
      end
      if ((ZERO_REG != 0) && (raddr[i*AW +: AW] == '0)) rd_word[i] = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata  <= '0;
      rvalid <= '0;
    end else begin
      for (int i = 0; i < NUM_RD; i++) begin
        rvalid[i] <= ready & read_en[i];
        if (ready && read_en[i]) rdata[i*DATA_W +: DATA_W] <= rd_word[i];
      end
    end
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Scoreboard bench for register_file_mp: a default 2R1W instance and a
// 2R2W zero-register instance, driven side by side from one stimulus flow.
module tb_register_file_mp;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  // instance 0: defaults (NUM_WR=1, ZERO_REG=0)
  logic         rdy0, cf0;
  logic [1:0]   re0, rv0;
  logic [9:0]   ra0;
  logic [127:0] rd0;
  logic [0:0]   we0;
  logic [4:0]   wa0;
  logic [63:0]  wd0;

  // instance 1: NUM_WR=2, ZERO_REG=1
  logic         rdy1, cf1;
  logic [1:0]   re1, rv1;
  logic [9:0]   ra1;
  logic [127:0] rd1;
  logic [1:0]   we1;
  logic [9:0]   wa1;
  logic [127:0] wd1;

  register_file_mp #(.DATA_W(64), .DEPTH(32), .NUM_RD(2), .NUM_WR(1), .ZERO_REG(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .ready(rdy0),
    .read_en(re0), .raddr(ra0), .rdata(rd0), .rvalid(rv0),
    .write_en(we0), .waddr(wa0), .wdata(wd0), .wr_conflict(cf0)
  );

  register_file_mp #(.DATA_W(64), .DEPTH(32), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .ready(rdy1),
    .read_en(re1), .raddr(ra1), .rdata(rd1), .rvalid(rv1),
    .write_en(we1), .waddr(wa1), .wdata(wd1), .wr_conflict(cf1)
  );

  logic [63:0] m0 [32];
  logic [63:0] m1 [32];
  logic [63:0] exp_q [4][$];   // 0,1: dut0 ports; 2,3: dut1 ports
  int checks;
  int failures;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    re0 = '0; ra0 = '0; we0 = '0; wa0 = '0; wd0 = '0;
    re1 = '0; ra1 = '0; we1 = '0; wa1 = '0; wd1 = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) begin
      m0[i] = '0;
      m1[i] = '0;
    end
  endtask

  // Writes must be issued before reads of the same cycle (write-first model).
  task automatic wr(input int d, input int p, input int a, input logic [63:0] v);
    if (d == 0) begin
      we0[p] = 1'b1; wa0 = 5'(a); wd0 = v; m0[a] = v;
    end else begin
      we1[p] = 1'b1; wa1[p*5 +: 5] = 5'(a); wd1[p*64 +: 64] = v;
      if (a != 0) m1[a] = v;
    end
  endtask

  task automatic rd(input int d, input int p, input int a);
    if (d == 0) begin
      re0[p] = 1'b1; ra0[p*5 +: 5] = 5'(a);
      exp_q[p].push_back(m0[a]);
    end else begin
      re1[p] = 1'b1; ra1[p*5 +: 5] = 5'(a);
      exp_q[2+p].push_back((a == 0) ? 64'd0 : m1[a]);
    end
  endtask

  // Release happens just after a posedge; ready must rise after exactly 32 cycles.
  task automatic init_wait(input string tag);
    int cnt;
    cnt = 0;
    while (!(rdy0 && rdy1) && cnt < 100) begin
      re0 = 2'b11; ra0 = {5'd3, 5'd3}; we0 = 1'b1; wa0 = 5'd3; wd0 = '1;
      re1 = 2'b11; ra1 = {5'd4, 5'd3}; we1 = 2'b11; wa1 = {5'd4, 5'd3}; wd1 = '1;
      tick();
      cnt++;
    end
    idle();
    check(tag, 64'(cnt), 64'd32);
    check({tag, "_rdy_same"}, 64'(rdy0 ^ rdy1), 64'd0);
  endtask

  // Output monitor: every rvalid pops one expected word for that port.
  logic        mon_v;
  logic [63:0] mon_d;
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 4; k++) begin
      mon_v = (k < 2) ? rv0[k] : rv1[k-2];
      mon_d = (k < 2) ? rd0[k*64 +: 64] : rd1[(k-2)*64 +: 64];
      if (mon_v) begin
        if (exp_q[k].size() == 0)
          check($sformatf("rvalid_spurious_p%0d", k), 64'(mon_v), 64'd0);
        else
          check($sformatf("rdata_p%0d", k), mon_d, exp_q[k].pop_front());
      end
    end
  end

  initial begin
    checks = 0;
    failures = 0;
    clear_model();
    reset_n = 1'b0;
    idle();
    repeat (3) tick();

    check("rst_ready", 64'({rdy1, rdy0}), 64'd0);
    check("rst_rvalid", 64'({rv1, rv0}), 64'd0);
    check("rst_rdata0", rd0[63:0] | rd0[127:64], 64'd0);
    check("rst_rdata1", rd1[63:0] | rd1[127:64], 64'd0);
    check("rst_conflict", 64'({cf1, cf0}), 64'd0);

    // 1: init length, then every entry reads 0 despite writes attempted during INIT
    reset_n = 1'b1;
    init_wait("init_cycles");
    for (int i = 0; i < 32; i++) begin
      rd(0, 0, i); rd(0, 1, 31 - i);
      rd(1, 0, i); rd(1, 1, 31 - i);
      tick(); idle();
    end
    tick();

    // 2: write then dual-port read of the same entry
    wr(0, 0, 5, 64'hDEAD_BEEF_0123_4567);
    wr(1, 0, 5, 64'hDEAD_BEEF_0123_4567);
    tick(); idle();
    rd(0, 0, 5); rd(0, 1, 5); rd(1, 0, 5); rd(1, 1, 5);
    tick(); idle();
    check("t2_rvalid0", 64'(rv0), 64'd3);
    check("t2_rvalid1", 64'(rv1), 64'd3);
    tick();
    check("t2_rvalid_drop", 64'({rv1, rv0}), 64'd0);
    check("t2_hold", rd0[127:64], 64'hDEAD_BEEF_0123_4567);

    // 3: same-cycle write + read returns the new data
    wr(0, 0, 7, 64'h7777); wr(1, 1, 7, 64'h7777);
    tick(); idle();
    wr(0, 0, 7, 64'h1111); wr(1, 1, 7, 64'h1111);
    rd(0, 0, 7); rd(1, 0, 7);
    tick(); idle();
    tick();

    // 4: two write ports on one address: highest port wins, conflict for one cycle
    wr(1, 0, 9, 64'hA); wr(1, 1, 9, 64'hB);
    tick(); idle();
    check("t4_conf1", 64'(cf1), 64'd1);
    check("t4_conf0", 64'(cf0), 64'd0);
    rd(1, 0, 9);
    tick(); idle();
    check("t4_conf_clear", 64'(cf1), 64'd0);
    wr(1, 0, 10, 64'hC); wr(1, 1, 11, 64'hD);
    tick(); idle();
    check("t4_distinct_noconf", 64'(cf1), 64'd0);
    rd(1, 0, 10); rd(1, 1, 11);
    tick(); idle();
    wr(1, 0, 12, 64'hE); wr(1, 1, 12, 64'hF);
    rd(1, 0, 12); rd(1, 1, 12);
    tick(); idle();
    check("t4_bypass_conf", 64'(cf1), 64'd1);

    // 5: zero register
    wr(1, 0, 0, 64'hFF);
    tick(); idle();
    rd(1, 0, 0);
    tick(); idle();
    wr(1, 1, 0, 64'hFF);
    rd(1, 0, 0); rd(1, 1, 0);
    tick(); idle();
    wr(1, 0, 0, 64'h1); wr(1, 1, 0, 64'h2);
    tick(); idle();
    check("t5_zero_conf", 64'(cf1), 64'd1);

    // random traffic against the model; dut1 uses a narrow address range for conflicts
    for (int n = 0; n < 150; n++) begin
      int a0, a1;
      bit e0, e1;
      logic exp_cf;
      a0 = $urandom_range(0, 3); a1 = $urandom_range(0, 3);
      e0 = 1'($urandom); e1 = 1'($urandom);
      exp_cf = e0 && e1 && (a0 == a1);
      if ($urandom % 2 == 0) wr(0, 0, $urandom_range(0, 31), {$urandom, $urandom});
      if (e0) wr(1, 0, a0, {$urandom, $urandom});
      if (e1) wr(1, 1, a1, {$urandom, $urandom});
      for (int p = 0; p < 2; p++) begin
        if ($urandom % 2 == 0) rd(0, p, $urandom_range(0, 31));
        if ($urandom % 2 == 0) rd(1, p, $urandom_range(0, 3));
      end
      tick(); idle();
      check("rand_conf1", 64'(cf1), 64'(exp_cf));
    end
    tick();

    // 6: reset again, abort INIT at init_ptr=10, full re-clear afterwards
    reset_n = 1'b0;
    #1;
    check("t6_rst_ready", 64'({rdy1, rdy0}), 64'd0);
    check("t6_rst_rdata", rd0[63:0] | rd0[127:64] | rd1[63:0] | rd1[127:64], 64'd0);
    tick();
    reset_n = 1'b1;
    repeat (10) tick();
    reset_n = 1'b0;
    #1;
    check("t6_mid_init_ready", 64'({rdy1, rdy0}), 64'd0);
    tick();
    reset_n = 1'b1;
    clear_model();
    init_wait("t6_init_cycles");
    rd(0, 0, 5); rd(0, 1, 7); rd(1, 0, 9); rd(1, 1, 12);
    tick(); idle();
    check("t6_rvalid", 64'({rv1, rv0}), 64'hF);
    repeat (2) tick();

    for (int k = 0; k < 4; k++) check($sformatf("q_empty_p%0d", k), 64'(exp_q[k].size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
